// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the phase sequencer: state codes, opcode fields and
// the decoded instruction-class bundle.
package phase_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    localparam logic [1:0] OP1_LD  = 2'b00;
    localparam logic [1:0] OP1_ST  = 2'b01;
    localparam logic [1:0] OP1_BR  = 2'b10;
    localparam logic [1:0] OP1_ALU = 2'b11;

    localparam logic [3:0] OP3_HLT = 4'b1111;

    typedef struct packed {
        logic ld;
        logic st;
        logic hlt;
        logic nop;
    } instr_class_t;

endpackage

// File: rtl/phase_sequencer_instr_class.sv
// Combinational instruction-class decode from the instruction register word.
module instr_class
    import phase_sequencer_pkg::*;
(
    input  logic [15:0]  instr_i,
    output instr_class_t class_o
);

    logic [1:0] op1;
    logic [3:0] op3;
    logic       is_nop;

    assign op1    = instr_i[15:14];
    assign op3    = instr_i[7:4];
    assign is_nop = (instr_i == 16'h0000);

    // The all-zero word sits in the LD opcode space but is a NOP, so LD excludes it.
    assign class_o = '{
        ld:  (op1 == OP1_LD) && !is_nop,
        st:  (op1 == OP1_ST),
        hlt: (op1 == OP1_ALU) && (op3 == OP3_HLT),
        nop: is_nop
    };

endmodule

// File: rtl/phase_sequencer.sv
// Multi-cycle instruction phase sequencer: FETCH/DECODE/EXEC/MEM/WB control
// with run/stop and single-step modes, halt, and a retired-instruction counter.
module phase_sequencer
    import phase_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        exec,
    input  logic        step,
    input  logic [15:0] instr,
    input  logic        mem_ready,
    output logic        ir_load,
    output logic        pc_load,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic        wb_en,
    output logic [2:0]  phase,
    output logic        running,
    output logic        halted,
    output logic [15:0] retired
);

    state_e       state_q, state_d;
    logic         single_q, single_d;
    logic         pending_q, pending_d;
    logic [15:0]  retired_q, retired_d;
    instr_class_t cls;

    instr_class u_instr_class (
        .instr_i (instr),
        .class_o (cls)
    );

    assign phase   = state_q;
    assign running = (state_q inside {ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB});
    assign halted  = (state_q == ST_HALT);
    assign retired = retired_q;

    always_comb begin
        // NOTE: every output and next-state gets a default first so no path infers a latch.
        state_d      = state_q;
        single_d     = single_q;
        pending_d    = pending_q;
        retired_d    = retired_q;
        ir_load      = 1'b0;
        pc_load      = 1'b0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        wb_en        = 1'b0;

        if (running && exec) pending_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                pending_d = 1'b0;
                if (exec) begin
                    state_d  = ST_FETCH;
                    single_d = 1'b0;
                end else if (step) begin
                    state_d  = ST_FETCH;
                    single_d = 1'b1;
                end
            end
            ST_FETCH: begin
                mem_read_en = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = (cls.ld || cls.st) ? ST_MEM : ST_WB;
            ST_MEM: begin
                mem_read_en  = cls.ld;
                mem_write_en = cls.st;
                if (mem_ready) state_d = ST_WB;
            end
            ST_WB: begin
                pc_load   = 1'b1;
                wb_en     = !(cls.st || cls.nop || cls.hlt);
                retired_d = retired_q + 16'd1;
                // A stop request arriving in the WB cycle itself takes effect at this boundary.
                if (cls.hlt) begin
                    state_d = ST_HALT;
                end else if (pending_q || exec || single_q) begin
                    state_d   = ST_IDLE;
                    pending_d = 1'b0;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            single_q  <= 1'b0;
            pending_q <= 1'b0;
            retired_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            single_q  <= single_d;
            pending_q <= pending_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench: random instruction streams checked against a
// transaction-level model that builds each instruction's expected phase walk.
module tb_phase_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        exec = 1'b0;
    logic        step = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        mem_ready = 1'b1;
    logic        ir_load, pc_load, mem_read_en, mem_write_en, wb_en;
    logic [2:0]  phase;
    logic        running, halted;
    logic [15:0] retired;

    int n_cmp = 0;
    int n_bad = 0;

    int m_retired = 0;
    bit m_single  = 1'b0;
    bit m_pending = 1'b0;
    int where     = 0;

    phase_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .exec         (exec),
        .step         (step),
        .instr        (instr),
        .mem_ready    (mem_ready),
        .ir_load      (ir_load),
        .pc_load      (pc_load),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .wb_en        (wb_en),
        .phase        (phase),
        .running      (running),
        .halted       (halted),
        .retired      (retired)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_cycle(input int ph, input bit rd, input bit wr, input bit irl,
                                input bit pcl, input bit wb);
        check("phase", {29'd0, phase}, ph);
        check("mem_read_en", {31'd0, mem_read_en}, {31'd0, rd});
        check("mem_write_en", {31'd0, mem_write_en}, {31'd0, wr});
        check("ir_load", {31'd0, ir_load}, {31'd0, irl});
        check("pc_load", {31'd0, pc_load}, {31'd0, pcl});
        check("wb_en", {31'd0, wb_en}, {31'd0, wb});
        check("running", {31'd0, running}, {31'd0, (ph >= 1 && ph <= 5)});
        check("halted", {31'd0, halted}, {31'd0, (ph == 6)});
        check("retired", {16'd0, retired}, m_retired);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_side(input int k, input int exec_at);
        exec = (k == exec_at);
        step = ($urandom_range(0, 1) == 0);
        if (exec) m_pending = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            exec = 1'b0;
            step = 1'b0;
            #4;
            expect_cycle(0, 0, 0, 0, 0, 0);
            next_cycle();
        end
    endtask

    // sel: 0 = exec, 1 = step, 2 = both in the same cycle (exec wins)
    task automatic launch(input int sel);
        exec = (sel != 1);
        step = (sel != 0);
        #4;
        expect_cycle(0, 0, 0, 0, 0, 0);
        next_cycle();
        exec = 1'b0;
        step = 1'b0;
        m_single  = (sel == 1);
        m_pending = 1'b0;
    endtask

    // Walks one instruction from its first FETCH cycle through WB.
    task automatic run_instr(input logic [15:0] ins, input int fw, input int mw,
                             input int exec_at, output int nxt);
        bit ld, st, hlt, nop;
        logic [1:0] op1;
        logic [3:0] op3;
        int k;
        k   = 0;
        op1 = ins[15:14];
        op3 = ins[7:4];
        nop = (ins == 16'h0000);
        ld  = (op1 == 2'b00) && !nop;
        st  = (op1 == 2'b01);
        hlt = (op1 == 2'b11) && (op3 == 4'hF);
        instr = ins;
        for (int c = 0; c <= fw; c++) begin
            mem_ready = (c == fw);
            drive_side(k, exec_at);
            #4;
            expect_cycle(1, 1, 0, (c == fw), 0, 0);
            next_cycle();
            k++;
        end
        for (int p = 2; p <= 3; p++) begin
            mem_ready = 1'($urandom_range(0, 1));
            drive_side(k, exec_at);
            #4;
            expect_cycle(p, 0, 0, 0, 0, 0);
            next_cycle();
            k++;
        end
        if (ld || st) begin
            for (int c = 0; c <= mw; c++) begin
                mem_ready = (c == mw);
                drive_side(k, exec_at);
                #4;
                expect_cycle(4, ld, st, 0, 0, 0);
                next_cycle();
                k++;
            end
        end
        mem_ready = 1'($urandom_range(0, 1));
        drive_side(k, exec_at);
        #4;
        expect_cycle(5, 0, 0, 0, 1, !(st || nop || hlt));
        next_cycle();
        m_retired = (m_retired + 1) % 65536;
        exec = 1'b0;
        step = 1'b0;
        mem_ready = 1'b1;
        if (hlt) begin
            nxt = 6;
        end else if (m_pending || m_single) begin
            nxt = 0;
            m_pending = 1'b0;
        end else begin
            nxt = 1;
        end
    endtask

    task automatic halt_cycles(input int n);
        repeat (n) begin
            exec = 1'($urandom_range(0, 1));
            step = 1'($urandom_range(0, 1));
            #4;
            expect_cycle(6, 0, 0, 0, 0, 0);
            next_cycle();
        end
        exec = 1'b0;
        step = 1'b0;
    endtask

    function automatic logic [15:0] rand_instr(input int cls);
        logic [15:0] r;
        logic [15:0] w;
        r = 16'($urandom);
        case (cls)
            0: begin
                w = {2'b00, r[13:0]};
                if (w == 16'h0000) w = 16'h0001;
            end
            1: w = {2'b01, r[13:0]};
            2: w = {2'b10, r[13:0]};
            3: begin
                w = {2'b11, r[13:0]};
                if (w[7:4] == 4'hF) w[7:4] = 4'h0;
            end
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    initial begin
        #3;
        expect_cycle(0, 0, 0, 0, 0, 0);
        #9 reset = 1'b1;
        next_cycle();

        // Directed sequences
        launch(0);
        run_instr(16'hC0A0, 0, 0, -1, where);
        run_instr(16'h0123, 0, 2, -1, where);
        run_instr(16'h4000, 1, 0, 2, where);
        idle_cycles(2);
        launch(1);
        run_instr(16'h8000, 0, 0, -1, where);
        idle_cycles(1);
        launch(2);

        // Randomized stream
        where = 1;
        for (int i = 0; i < 40; i++) begin
            int fw, mw, ex, cls;
            if (where == 0) begin
                idle_cycles($urandom_range(0, 2));
                launch($urandom_range(0, 2));
            end
            cls = $urandom_range(0, 4);
            fw  = $urandom_range(0, 2);
            mw  = $urandom_range(0, 2);
            ex  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1;
            run_instr(rand_instr(cls), fw, mw, ex, where);
        end

        // Halt is absorbing
        if (where == 0) launch(0);
        run_instr(16'hC0F0, 0, 0, -1, where);
        halt_cycles(6);

        // Async reset out of HALT
        #2 reset = 1'b0;
        m_retired = 0;
        #1;
        expect_cycle(0, 0, 0, 0, 0, 0);
        @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #1;
        idle_cycles(1);

        // Counter wrap from a preloaded 0xFFFF
        force dut.retired_q = 16'hFFFF;
        next_cycle();
        release dut.retired_q;
        m_retired = 16'hFFFF;
        idle_cycles(1);
        launch(0);
        run_instr(16'hC0A0, 0, 0, 3, where);
        idle_cycles(1);
        launch(0);
        run_instr(16'h8000, 0, 0, 0, where);
        idle_cycles(1);

        // Reset while MEM has a read outstanding
        launch(0);
        instr = 16'h0123;
        mem_ready = 1'b1;
        #4;
        expect_cycle(1, 1, 0, 1, 0, 0);
        next_cycle();
        for (int p = 2; p <= 3; p++) begin
            #4;
            expect_cycle(p, 0, 0, 0, 0, 0);
            next_cycle();
        end
        mem_ready = 1'b0;
        #4;
        expect_cycle(4, 1, 0, 0, 0, 0);
        #2 reset = 1'b0;
        m_retired = 0;
        #1;
        expect_cycle(0, 0, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        expect_cycle(0, 0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        mem_ready = 1'b1;
        @(posedge clock);
        #1;
        idle_cycles(1);
        launch(0);
        run_instr(16'hC0A0, 0, 0, 0, where);
        idle_cycles(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
